// File: rtl/aes_pkg.sv
// aes_pkg
//   Shared constants and types for the AES inverse word-substitution engine.
//   - AES_STATE_W / AES_WORD_W / AES_BYTE_W : fixed datapath widths
//   - aes_fsm_e                            : engine FSM encoding (IDLE/BUSY/DONE)
//   - INV_SBOX                             : FIPS-197 inverse S-box, indexed by byte value
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_WORD_W  = 32;
  localparam int AES_BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aes_fsm_e;

  // Row r, column c of the usual 16x16 presentation sits at index 16*r + c.
  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox
//   Combinational inverse substitution of one 32-bit word: four independent
//   byte lookups into the inverse S-box. Bytes never mix across lanes.
//   Ports:
//     word_i  in  32  word to substitute
//     word_o  out 32  InvSbox applied to each byte of word_i, same lane order
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [AES_WORD_W-1:0] word_i,
  output logic [AES_WORD_W-1:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int i = 0; i < AES_WORD_W / AES_BYTE_W; i++) begin
      word_o[AES_BYTE_W*i +: AES_BYTE_W] = INV_SBOX[word_i[AES_BYTE_W*i +: AES_BYTE_W]];
    end
  end

endmodule

// File: rtl/aes_inv_subbytes_seq.sv
// aes_inv_subbytes_seq
//   Sequential AES InvSubBytes: a 128-bit state is accepted, substituted one
//   32-bit word per cycle through a single aes_inv_sbox, then offered out.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. in_ready is high only in IDLE; out_valid is high only in DONE
//   and, once high, out_valid/out_state hold until out_ready is seen.
//
//   Ports:
//     clk        in   1    rising-edge clock
//     rst        in   1    synchronous active-high reset
//     in_valid   in   1    in_state is valid
//     in_ready   out  1    engine can accept a state (IDLE)
//     in_state   in   128  input state, word 0 = [127:96], word 3 = [31:0]
//     out_valid  out  1    out_state holds a completed result (DONE)
//     out_ready  in   1    consumer accepts out_state
//     out_state  out  128  substituted state, same ordering as in_state
//     busy       out  1    high in BUSY or DONE
//     dbg_state  out  2    current FSM state, for observation only
module aes_inv_subbytes_seq
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy,
  output aes_fsm_e               dbg_state
);

  aes_fsm_e               state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] buf_q, buf_d;

  logic [AES_WORD_W-1:0]  word_sel;
  logic [AES_WORD_W-1:0]  word_sub;

  // Word 0 is the most significant word of the state.
  always_comb begin
    word_sel = '0;
    case (cnt_q)
      2'd0:    word_sel = buf_q[127:96];
      2'd1:    word_sel = buf_q[95:64];
      2'd2:    word_sel = buf_q[63:32];
      default: word_sel = buf_q[31:0];
    endcase
  end

  aes_inv_sbox u_inv_sbox (
    .word_i (word_sel),
    .word_o (word_sub)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d   = in_state;
          cnt_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        case (cnt_q)
          2'd0:    buf_d[127:96] = word_sub;
          2'd1:    buf_d[95:64]  = word_sub;
          2'd2:    buf_d[63:32]  = word_sub;
          default: buf_d[31:0]   = word_sub;
        endcase
        // Wraps to 0 after the last word; it is reloaded on the next accept anyway.
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  // All handshake outputs come straight from the state flops.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY) || (state_q == DONE);
  assign out_state = buf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_inv_subbytes_seq.sv
// tb_aes_inv_subbytes_seq
//   Directed and randomized checks of aes_inv_subbytes_seq. Expected values are
//   hand-entered vectors or derived from the forward S-box table held here.
module tb_aes_inv_subbytes_seq;

  localparam logic [7:0] FWD_SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [127:0] KNOWN_IN  = 128'h637c777b_f26b6fc5_3001672b_fed7ab76;
  localparam logic [127:0] KNOWN_OUT = 128'h00010203_04050607_08090a0b_0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_state;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  aes_inv_subbytes_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents st until the engine takes it; returns just after the accept edge.
  task automatic accept_state(input logic [127:0] st);
    int n;
    n = 0;
    in_state = st;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Counts cycles after the accept edge until out_valid is seen (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  function automatic logic [127:0] fwd_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = FWD_SBOX[s[8*i +: 8]];
    return r;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_ready/out_valid/busy=%b%b%b, required 100", in_ready, out_valid, busy);
    end
    n_checks++;
    if (out_state !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_state: out_state=%h, required 0", out_state);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_known_vector();
    int lat;
    out_ready = 1'b1;
    accept_state(KNOWN_IN);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL known_busy: busy=%b in_ready=%b, required 1 0", busy, in_ready);
    end
    wait_out(lat);
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL known_latency: %0d cycles, required 4", lat);
    end
    n_checks++;
    if (out_state !== KNOWN_OUT) begin
      n_fail++;
      $display("FAIL known_data: out_state=%h, required %h", out_state, KNOWN_OUT);
    end
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL known_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_patterns();
    logic [127:0] ins  [3];
    logic [127:0] exps [3];
    int lat;
    ins[0] = 128'h0;              exps[0] = {16{8'h52}};
    ins[1] = {16{8'h16}};         exps[1] = {16{8'hff}};
    ins[2] = 128'h00520063_ed000000_00000000_0000ed63;
    exps[2] = 128'h52485200_53525252_52525252_52525300;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      accept_state(ins[i]);
      wait_out(lat);
      n_checks++;
      if (out_valid !== 1'b1 || out_state !== exps[i]) begin
        n_fail++;
        $display("FAIL pattern_%0d: out_valid=%b out_state=%h, required 1 %h", i, out_valid, out_state, exps[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    out_ready = 1'b0;
    accept_state(KNOWN_IN);
    wait_out(lat);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      in_state = {4{$urandom}};
      tick();
      if (out_valid !== 1'b1 || out_state !== KNOWN_OUT || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: %0d unstable cycles, required 0 (last out_state=%h)", bad, out_state);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    // Nothing pulsed during the hold may have been queued.
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_no_queue: busy=%b in_ready=%b, required 0 1", busy, in_ready);
    end
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    out_ready = 1'b1;
    accept_state(KNOWN_IN);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_state !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_mid_busy: in_ready=%b out_valid=%b out_state=%h, required 1 0 0",
               in_ready, out_valid, out_state);
    end
    accept_state(128'h0);
    wait_out(lat);
    n_checks++;
    if (lat !== 4 || out_state !== {16{8'h52}}) begin
      n_fail++;
      $display("FAIL reset_recover: latency=%0d out_state=%h, required 4 %h", lat, out_state, {16{8'h52}});
    end
    tick();
  endtask

  task automatic test_exhaustive();
    int lat;
    int bad;
    logic [7:0] b;
    logic [7:0] ob;
    out_ready = 1'b1;
    for (int v = 0; v < 256; v++) begin
      b = v[7:0];
      accept_state({16{b}});
      wait_out(lat);
      bad = 0;
      ob = out_state[7:0];
      for (int j = 0; j < 16; j++) begin
        if (FWD_SBOX[out_state[8*j +: 8]] !== b || out_state[8*j +: 8] !== ob) bad++;
      end
      n_checks++;
      if (!out_valid || bad != 0) begin
        n_fail++;
        $display("FAIL exhaustive_%02h: out_valid=%b out_state=%h, required bytes x with Sbox[x]=%02h",
                 b, out_valid, out_state, b);
      end
      if (b == 8'h00 || b == 8'h52 || b == 8'hed || b == 8'h63) begin
        n_checks++;
        if ((b == 8'h00 && ob !== 8'h52) || (b == 8'h52 && ob !== 8'h48) ||
            (b == 8'hed && ob !== 8'h53) || (b == 8'h63 && ob !== 8'h00)) begin
          n_fail++;
          $display("FAIL spot_%02h: got %02h", b, ob);
        end
      end
      tick();
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] exp_q [$];
    logic [127:0] orig;
    logic [127:0] exp_v;
    int bad;
    int n;
    bad = 0;
    for (int t = 0; t < 1000; t++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(orig);
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      accept_state(fwd_state(orig));
      n = 0;
      while (n < 40) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) break;
        tick();
        n++;
      end
      exp_v = exp_q.pop_front();
      if (!(out_valid && out_ready) || out_state !== exp_v) begin
        bad++;
        if (bad <= 5) $display("FAIL round_trip_%0d: out_valid=%b out_state=%h, required 1 %h",
                               t, out_valid, out_state, exp_v);
      end
      tick();
    end
    out_ready = 1'b1;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL round_trip: %0d of 1000 states wrong, required 0", bad);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_known_vector();
    test_patterns();
    test_backpressure();
    test_reset_mid_busy();
    test_exhaustive();
    test_round_trip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
